// File: rtl/sr_bank_driver.sv
// SR flip-flop bank driver: drives a target pattern onto an SR bank,
// verifies q/qbar feedback, retries up to MAX_TRY times.
module sr_bank_driver #(
  parameter int WIDTH   = 8,
  parameter int MAX_TRY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] qbar_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK
  } state_e;

  localparam logic [3:0] MaxTry = 4'(MAX_TRY);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [3:0]       try_q, try_d;
  logic [WIDTH-1:0] err_mask_q, err_mask_d;
  logic [WIDTH-1:0] fail_vec;
  logic [WIDTH-1:0] s_cmd;

  // qbar must be the complement of target; q==qbar always fails one term
  assign fail_vec = (q_in ^ target_q) | ~(qbar_in ^ target_q);
  assign s_cmd    = target_q & ~q_in;

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign err_mask  = err_mask_q;

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    try_d      = try_q;
    err_mask_d = err_mask_q;
    s_out      = '0;
    r_out      = '0;
    done       = 1'b0;
    err        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          target_d   = req_data;
          try_d      = 4'd1;
          err_mask_d = '0;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        // reset term masked by set term so the pair can never overlap
        s_out   = s_cmd;
        r_out   = ~target_q & q_in & ~s_cmd;
        state_d = SETTLE;
      end
      SETTLE: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (fail_vec == '0) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (try_q < MaxTry) begin
          try_d   = try_q + 4'd1;
          state_d = DRIVE;
        end else begin
          err        = 1'b1;
          err_mask_d = fail_vec;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      try_q      <= '0;
      err_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      try_q      <= try_d;
      err_mask_q <= err_mask_d;
    end
  end

endmodule

// File: tb/tb_sr_bank_driver.sv
// Directed testbench for sr_bank_driver with a behavioural SR bank
// (stuck-at-0 mask and q/qbar short on bit 0 available).
module tb_sr_bank_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_data = '0;
  logic [7:0] s_out;
  logic [7:0] r_out;
  logic [7:0] q_in;
  logic [7:0] qbar_in;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] err_mask;

  logic [7:0] bank;
  logic       bank_load = 1'b0;
  logic [7:0] bank_val = '0;
  logic [7:0] stuck0 = '0;
  logic       force_q0 = 1'b0;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  sr_bank_driver #(.WIDTH(8), .MAX_TRY(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_data (req_data),
    .s_out    (s_out),
    .r_out    (r_out),
    .q_in     (q_in),
    .qbar_in  (qbar_in),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_mask (err_mask)
  );

  always @(posedge clk) begin
    if (bank_load) bank <= bank_val;
    else           bank <= ((bank | s_out) & ~r_out) & ~stuck0;
  end

  assign q_in    = force_q0 ? (bank | 8'h01) : bank;
  assign qbar_in = force_q0 ? (~bank | 8'h01) : ~bank;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bank(input logic [7:0] v);
    bank_load = 1'b1;
    bank_val  = v;
    step();
    bank_load = 1'b0;
  endtask

  task automatic issue(input logic [7:0] d);
    req_valid = 1'b1;
    req_data  = d;
    step();
    req_valid = 1'b0;
  endtask

  task automatic observe(input int limit, input logic [7:0] s_pat,
                         output int done_at, output int err_at,
                         output int drv_cnt, output int ovl,
                         output logic [7:0] q_done);
    done_at = 0;
    err_at  = 0;
    drv_cnt = 0;
    ovl     = 0;
    q_done  = '0;
    for (int n = 1; n <= limit; n++) begin
      if ((s_out & r_out) != 8'h00) ovl++;
      if (done && err) ovl++;
      if (s_out == s_pat) drv_cnt++;
      if (done && done_at == 0) begin
        done_at = n;
        q_done  = q_in;
      end
      if (err && err_at == 0) err_at = n;
      if (done_at != 0 || err_at != 0) break;
      step();
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 1'b1;
    req_data  = 8'hFF;
    set_bank(8'h00);
    step();
    chk_cnt++;
    if (req_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", req_ready);
    else pass_cnt++;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy);
    else pass_cnt++;
    chk_cnt++;
    if ({s_out, r_out} !== 16'h0) $display("FAIL rst_cmd got %h want 0000", {s_out, r_out});
    else pass_cnt++;
    chk_cnt++;
    if ({done, err} !== 2'b00) $display("FAIL rst_pulse got %b want 00", {done, err});
    else pass_cnt++;
    chk_cnt++;
    if (err_mask !== 8'h00) $display("FAIL rst_mask got %h want 00", err_mask);
    else pass_cnt++;
    rst       = 1'b0;
    req_valid = 1'b0;
    step();
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_no_accept got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int d, e, c, o;
    logic [7:0] qd;
    set_bank(8'h00);
    issue(8'hA5);
    chk_cnt++;
    if (s_out !== 8'hA5 || r_out !== 8'h00)
      $display("FAIL basic_cmd got s=%h r=%h want s=a5 r=00", s_out, r_out);
    else pass_cnt++;
    observe(12, 8'hA5, d, e, c, o, qd);
    chk_cnt++;
    if (d !== 3) $display("FAIL basic_done_lat got %0d want 3", d);
    else pass_cnt++;
    chk_cnt++;
    if (qd !== 8'hA5) $display("FAIL basic_q got %h want a5", qd);
    else pass_cnt++;
    chk_cnt++;
    if (e !== 0) $display("FAIL basic_err got %0d want 0", e);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse got %b want 0", done);
    else pass_cnt++;
  endtask

  task automatic test_mixed();
    int d, e, c, o;
    logic [7:0] qd;
    set_bank(8'hF0);
    issue(8'h3C);
    chk_cnt++;
    if (s_out !== 8'h0C || r_out !== 8'hC0)
      $display("FAIL mixed_cmd got s=%h r=%h want s=0c r=c0", s_out, r_out);
    else pass_cnt++;
    observe(12, 8'h0C, d, e, c, o, qd);
    chk_cnt++;
    if (d !== 3) $display("FAIL mixed_done_lat got %0d want 3", d);
    else pass_cnt++;
    chk_cnt++;
    if (o !== 0) $display("FAIL mixed_overlap got %0d want 0", o);
    else pass_cnt++;
    step();
  endtask

  task automatic test_stuck();
    int d, e, c, o;
    logic [7:0] qd;
    set_bank(8'h00);
    stuck0 = 8'h04;
    issue(8'h04);
    observe(20, 8'h04, d, e, c, o, qd);
    chk_cnt++;
    if (e !== 9) $display("FAIL stuck_err_lat got %0d want 9", e);
    else pass_cnt++;
    chk_cnt++;
    if (c !== 3) $display("FAIL stuck_drives got %0d want 3", c);
    else pass_cnt++;
    chk_cnt++;
    if (d !== 0) $display("FAIL stuck_done got %0d want 0", d);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (err_mask !== 8'h04) $display("FAIL stuck_mask got %h want 04", err_mask);
    else pass_cnt++;
    chk_cnt++;
    if (err !== 1'b0 || busy !== 1'b0)
      $display("FAIL stuck_after got err=%b busy=%b want 0 0", err, busy);
    else pass_cnt++;
    stuck0 = 8'h00;
    step();
    chk_cnt++;
    if (err_mask !== 8'h04) $display("FAIL stuck_mask_hold got %h want 04", err_mask);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int d, e, c, o;
    logic [7:0] qd;
    issue(8'h81);
    chk_cnt++;
    if (err_mask !== 8'h00) $display("FAIL b2b_mask_clear got %h want 00", err_mask);
    else pass_cnt++;
    observe(12, 8'h81, d, e, c, o, qd);
    chk_cnt++;
    if (d !== 3) $display("FAIL b2b_done_lat got %0d want 3", d);
    else pass_cnt++;
    step();
  endtask

  task automatic test_same();
    int d, e, c, o;
    logic [7:0] qd;
    set_bank(8'h55);
    issue(8'h55);
    chk_cnt++;
    if (s_out !== 8'h00 || r_out !== 8'h00 || busy !== 1'b1)
      $display("FAIL same_cmd got s=%h r=%h busy=%b want 00 00 1", s_out, r_out, busy);
    else pass_cnt++;
    req_valid = 1'b1;
    req_data  = 8'hFF;
    chk_cnt++;
    if (req_ready !== 1'b0) $display("FAIL same_ready got %b want 0", req_ready);
    else pass_cnt++;
    step();
    step();
    req_valid = 1'b0;
    chk_cnt++;
    if (done !== 1'b1 || q_in !== 8'h55)
      $display("FAIL same_done got done=%b q=%h want 1 55", done, q_in);
    else pass_cnt++;
    observe(4, 8'hFF, d, e, c, o, qd);
    step();
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL same_busy_ignored got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_qshort();
    int d, e, c, o;
    logic [7:0] qd;
    set_bank(8'h00);
    force_q0 = 1'b1;
    issue(8'h00);
    observe(20, 8'hFF, d, e, c, o, qd);
    chk_cnt++;
    if (e !== 9 || d !== 0)
      $display("FAIL qshort_err got err_at=%0d done_at=%0d want 9 0", e, d);
    else pass_cnt++;
    chk_cnt++;
    if (o !== 0) $display("FAIL qshort_overlap got %0d want 0", o);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (err_mask !== 8'h01) $display("FAIL qshort_mask got %h want 01", err_mask);
    else pass_cnt++;
    force_q0 = 1'b0;
  endtask

  task automatic test_mid_reset();
    int bad;
    set_bank(8'h00);
    issue(8'h0F);
    chk_cnt++;
    if (s_out !== 8'h0F) $display("FAIL midrst_drive got %h want 0f", s_out);
    else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cnt++;
    if ({s_out, r_out} !== 16'h0 || busy !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL midrst_state got s=%h r=%h busy=%b ready=%b want 00 00 0 1",
               s_out, r_out, busy, req_ready);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || err || busy) bad++;
      step();
    end
    chk_cnt++;
    if (bad !== 0) $display("FAIL midrst_pulses got %0d want 0", bad);
    else pass_cnt++;
    chk_cnt++;
    if (err_mask !== 8'h00) $display("FAIL midrst_mask got %h want 00", err_mask);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mixed();
    test_stuck();
    test_back_to_back();
    test_same();
    test_qshort();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sr_bank_driver.md
SR_BANK_DRIVER -- requirements
Module: sr_bank_driver

Parameters
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of SR flip-flop bits driven.
REQ-002 The block SHALL have parameter MAX_TRY, default 3, giving the maximum drive attempts per request (legal range 1-15).

Interface
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 req_valid  input  1  requester has a target value on req_data.
REQ-006 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-007 req_data  input  WIDTH  target q value for the flip-flop bank.
REQ-008 s_out  output  WIDTH  per-bit set command to the SR bank.
REQ-009 r_out  output  WIDTH  per-bit reset command to the SR bank.
REQ-010 q_in  input  WIDTH  q feedback from the SR bank.
REQ-011 qbar_in  input  WIDTH  qbar feedback from the SR bank.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse: bank verified equal to target.
REQ-014 err  output  1  one-cycle pulse: MAX_TRY attempts exhausted without match.
REQ-015 err_mask  output  WIDTH  bits that failed on the final check; held until the next accepted request.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE, SETTLE, CHECK.
REQ-017 Handshake: a request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; req_data SHALL be captured into an internal target register; the FSM SHALL then go IDLE->DRIVE and the try counter SHALL load 1.
REQ-018 While busy, req_valid SHALL be ignored and req_data SHALL NOT affect the target.
REQ-019 DRIVE (exactly one cycle): for each bit i, s_out[i]=target[i]&~q_in[i] and r_out[i]=~target[i]&q_in[i]; the next state SHALL be SETTLE.
REQ-020 s_out[i] and r_out[i] SHALL never both be 1 in any cycle, including when q_in is X or inconsistent.
REQ-021 In every state other than DRIVE, s_out and r_out SHALL be all zeros.
REQ-022 SETTLE (exactly one cycle) SHALL drive no commands; the next state SHALL be CHECK.
REQ-023 CHECK: bit i SHALL fail if q_in[i]!=target[i] or qbar_in[i]!=~target[i], including q_in[i]==qbar_in[i].
REQ-024 CHECK with no failing bit: done SHALL pulse for that cycle and the next state SHALL be IDLE.
REQ-025 CHECK with a failing bit and try count < MAX_TRY: the try count SHALL increment and the next state SHALL be DRIVE.
REQ-026 CHECK with a failing bit and try count == MAX_TRY: err SHALL pulse, err_mask SHALL load the fail vector, and the next state SHALL be IDLE.
REQ-027 done and err SHALL never be high in the same cycle.
REQ-028 Latency from the accept edge to the done pulse SHALL be 3 cycles (DRIVE, SETTLE, CHECK) when the first attempt succeeds, plus 3 cycles per retry.
REQ-029 A target equal to the current bank value SHALL still run DRIVE (all-zero commands), SETTLE, and CHECK, and SHALL end in done.
REQ-030 err_mask SHALL clear to zero on each accepted request.

Reset
REQ-031 rst=1 SHALL force the following on the next rising edge, from any state including mid-DRIVE: state IDLE; s_out=0; r_out=0; done=0; err=0; busy=0; req_ready=1; err_mask=0; target=0; try count=0.
REQ-032 A request presented during a reset cycle SHALL NOT be accepted.

Verification
REQ-033 WIDTH=8, bank model at 8'h00, request 8'hA5 -> DRIVE cycle s_out=8'hA5, r_out=8'h00; done 3 cycles after the accept edge; q_in=8'hA5.
REQ-034 Bank at 8'hF0, request 8'h3C -> s_out=8'h0C, r_out=8'hC0; done; no cycle with s_out&r_out nonzero.
REQ-035 Bank model with bit 2 stuck at 0, request 8'h04, MAX_TRY=3 -> three DRIVE cycles each with s_out=8'h04; err pulse 9 cycles after the accept edge; err_mask=8'h04; done never asserted.
REQ-036 Bank at 8'h55, request 8'h55 -> DRIVE with s_out=r_out=0; done at +3; a second req_valid asserted while busy is not accepted (req_ready=0).
REQ-037 q_in[0]=qbar_in[0]=1 forced on every check -> bit 0 fails; err with err_mask[0]=1 after MAX_TRY attempts.
REQ-038 rst asserted in the DRIVE cycle -> next edge: s_out=r_out=0, busy=0, req_ready=1, no done or err pulse.
